// File: rtl/fx3_slave_fifo_emu.sv
// FX3 GPIF-II slave FIFO emulator: TX socket (master writes, host drains) and RX socket (host fills, master reads).
// Optional FX3_EMU_PROTO_CHECK_EN adds a sticky proto_err output for bus protocol violations.
module fx3_slave_fifo_emu #(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned TX_WM      = 4,
    parameter int unsigned RX_WM      = 4,
    parameter logic [1:0]  TX_ADDR    = 2'b00,
    parameter logic [1:0]  RX_ADDR    = 2'b11
) (
    input  logic        clk_pll,
    input  logic        reset_,
    input  logic        slcs_n,
    input  logic [1:0]  addr,
    input  logic        slrd_n,
    input  logic        sloe_n,
    input  logic        slwr_n,
    input  logic        pktend_n,
    input  logic [31:0] dq_in,
    output logic [31:0] dq_out,
    output logic        dq_oe,
    output logic        flaga,
    output logic        flagb,
    output logic        flagc,
    output logic        flagd,
    input  logic [31:0] host_in_data,
    input  logic        host_in_valid,
    output logic        host_in_ready,
    output logic [31:0] host_out_data,
    output logic        host_out_valid,
    input  logic        host_out_ready,
    output logic [31:0] tx_words,
    output logic [31:0] rx_words,
    output logic        err_ovf,
    output logic        err_udf
`ifdef FX3_EMU_PROTO_CHECK_EN
    ,
    output logic        proto_err
`endif
);

    localparam int unsigned AW    = DEPTH_LOG2;
    localparam int unsigned PW    = DEPTH_LOG2 + 1;
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    logic [31:0]   tx_mem [DEPTH];
    logic [31:0]   rx_mem [DEPTH];

    logic [PW-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
    logic [PW-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
    logic [PW-1:0] tx_cnt_c, rx_cnt_c, tx_cnt_d, rx_cnt_d;
    logic          tx_full_c, tx_empty_c, rx_full_c, rx_empty_c;
    logic          wr_hit_c, rd_hit_c, oe_hit_c;
    logic          tx_push_c, tx_pop_c, rx_push_c, rx_pop_c;
    logic [31:0]   tx_words_q, rx_words_q;
    logic          err_ovf_q, err_udf_q;
    logic          flaga_q, flagb_q, flagc_q, flagd_q;
    logic          dq_oe_q;
    logic [31:0]   dq_out_q;
    logic          s1_vld_q, s2_vld_q;
    logic [31:0]   s1_data_q, s2_data_q;

    // Occupancy from free-running pointers; the extra MSB separates full from empty
    assign tx_cnt_c   = tx_wptr_q - tx_rptr_q;
    assign rx_cnt_c   = rx_wptr_q - rx_rptr_q;
    assign tx_full_c  = (tx_cnt_c == PW'(DEPTH));
    assign rx_full_c  = (rx_cnt_c == PW'(DEPTH));
    assign tx_empty_c = (tx_cnt_c == '0);
    assign rx_empty_c = (rx_cnt_c == '0);

    assign wr_hit_c = !slcs_n && !slwr_n && (addr == TX_ADDR);
    assign rd_hit_c = !slcs_n && !slrd_n && (addr == RX_ADDR);
    assign oe_hit_c = !slcs_n && !sloe_n && (addr == RX_ADDR);

    // A host pop on a full TX socket frees the slot the same edge a master write lands in
    assign tx_pop_c  = !tx_empty_c && host_out_ready;
    assign tx_push_c = wr_hit_c && (!tx_full_c || tx_pop_c);
    assign rx_push_c = host_in_valid && !rx_full_c;
    assign rx_pop_c  = rd_hit_c && !rx_empty_c;

    assign tx_wptr_d = tx_wptr_q + PW'(tx_push_c);
    assign tx_rptr_d = tx_rptr_q + PW'(tx_pop_c);
    assign rx_wptr_d = rx_wptr_q + PW'(rx_push_c);
    assign rx_rptr_d = rx_rptr_q + PW'(rx_pop_c);
    assign tx_cnt_d  = tx_wptr_d - tx_rptr_d;
    assign rx_cnt_d  = rx_wptr_d - rx_rptr_d;

    always_ff @(posedge clk_pll) begin
        if (tx_push_c) tx_mem[tx_wptr_q[AW-1:0]] <= dq_in;
        if (rx_push_c) rx_mem[rx_wptr_q[AW-1:0]] <= host_in_data;
    end

    always_ff @(posedge clk_pll or negedge reset_) begin
        if (!reset_) begin
            tx_wptr_q  <= '0;
            tx_rptr_q  <= '0;
            rx_wptr_q  <= '0;
            rx_rptr_q  <= '0;
            tx_words_q <= '0;
            rx_words_q <= '0;
            err_ovf_q  <= 1'b0;
            err_udf_q  <= 1'b0;
            flaga_q    <= 1'b0;
            flagb_q    <= 1'b0;
            flagc_q    <= 1'b0;
            flagd_q    <= 1'b0;
            dq_oe_q    <= 1'b0;
            dq_out_q   <= '0;
            s1_vld_q   <= 1'b0;
            s1_data_q  <= '0;
            s2_vld_q   <= 1'b0;
            s2_data_q  <= '0;
        end else begin
            tx_wptr_q  <= tx_wptr_d;
            tx_rptr_q  <= tx_rptr_d;
            rx_wptr_q  <= rx_wptr_d;
            rx_rptr_q  <= rx_rptr_d;
            tx_words_q <= tx_words_q + 32'(tx_push_c);
            rx_words_q <= rx_words_q + 32'(rd_hit_c);
            if (wr_hit_c && !tx_push_c) err_ovf_q <= 1'b1;
            if (rd_hit_c && rx_empty_c) err_udf_q <= 1'b1;
            flaga_q    <= (tx_cnt_d != PW'(DEPTH));
            flagb_q    <= ((PW'(DEPTH) - tx_cnt_d) > PW'(TX_WM));
            flagc_q    <= (rx_cnt_d != '0);
            flagd_q    <= (rx_cnt_d > PW'(RX_WM));
            dq_oe_q    <= oe_hit_c;
            // Read pipe: underflow strobes carry a valid zero word
            s1_vld_q   <= rd_hit_c;
            s1_data_q  <= rx_pop_c ? rx_mem[rx_rptr_q[AW-1:0]] : 32'h0;
            s2_vld_q   <= s1_vld_q;
            s2_data_q  <= s1_data_q;
            if (s2_vld_q) dq_out_q <= s2_data_q;
        end
    end

`ifdef FX3_EMU_PROTO_CHECK_EN
    logic [1:0] addr_q;
    logic       strobe_q;
    logic       proto_err_q;
    logic       strobe_c;
    logic       proto_set_c;

    assign strobe_c    = !slcs_n && (!slrd_n || !slwr_n);
    assign proto_set_c = !slcs_n && ((!slrd_n && !slwr_n) ||
                                     (strobe_c && strobe_q && (addr != addr_q)) ||
                                     (!sloe_n && (addr != RX_ADDR)) ||
                                     (!pktend_n && (addr != TX_ADDR)));

    always_ff @(posedge clk_pll or negedge reset_) begin
        if (!reset_) begin
            addr_q      <= '0;
            strobe_q    <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            addr_q   <= addr;
            strobe_q <= strobe_c;
            if (proto_set_c) proto_err_q <= 1'b1;
        end
    end

    assign proto_err = proto_err_q;
`else
    // Zero-length packets carry no data, so pktend_n has no effect on the sockets
    logic unused_pktend_c;
    assign unused_pktend_c = pktend_n;
`endif

    assign dq_out         = dq_out_q;
    assign dq_oe          = dq_oe_q;
    assign flaga          = flaga_q;
    assign flagb          = flagb_q;
    assign flagc          = flagc_q;
    assign flagd          = flagd_q;
    assign tx_words       = tx_words_q;
    assign rx_words       = rx_words_q;
    assign err_ovf        = err_ovf_q;
    assign err_udf        = err_udf_q;
    assign host_in_ready  = !rx_full_c;
    assign host_out_valid = !tx_empty_c;
    assign host_out_data  = tx_mem[tx_rptr_q[AW-1:0]];

endmodule
